// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver fed by an already-synchronized RX line. It recovers 8-bit
//   frames (LSB first, optional parity, one stop bit) by mid-bit sampling. It
//   presents each good byte on a valid/ready interface, and reports frame,
//   parity and overrun conditions as one-cycle pulses.
//
// Ports
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   rx_sync_i     synchronized RX line level (idle high)
//   rx_fall_i     one-cycle falling-edge strobe of rx_sync_i
//   data_o        received byte, stable while valid_o is high
//   valid_o       byte available, held until accepted
//   ready_i       consumer accepts data_o when valid_o & ready_i
//   frame_err_o   pulse: stop bit sampled low
//   parity_err_o  pulse: parity mismatch
//   overrun_o     pulse: good frame dropped because valid_o was still held
//   busy_o        high in every state except IDLE
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_sync_i,
  input  logic       rx_fall_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);
  localparam logic             PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bad_q;

  logic expire;
  logic stop_smp;
  logic frame_bad;
  logic par_hit;
  logic good;
  logic load;
  logic drop;

  // The counter is loaded with the full count, so it reaches one on the cycle
  // that holds the sample point.
  assign expire = (cnt_q == CNT_ONE);

  // ---- state register ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rx_fall_i) state_d = S_START;
      S_START:  if (expire) state_d = rx_sync_i ? S_IDLE : S_DATA;
      S_DATA:   if (expire && (idx_q == 3'd7)) state_d = PAR_ON ? S_PARITY : S_STOP;
      S_PARITY: if (expire) state_d = S_STOP;
      S_STOP:   if (expire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---- output / event decode ----
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    stop_smp  = (state_q == S_STOP) && expire;
    frame_bad = stop_smp && !rx_sync_i;
    par_hit   = stop_smp && rx_sync_i && par_bad_q;
    good      = stop_smp && rx_sync_i && !par_bad_q;
    // A byte may still load while the previous one is being accepted.
    load      = good && (!valid_o || ready_i);
    drop      = good && !load;
  end

  // ---- bit timing and deserialization ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        if (rx_fall_i) cnt_q <= CNT_HALF;
      end else if (expire) begin
        cnt_q <= CNT_FULL;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end

      if (expire) begin
        case (state_q)
          S_START: begin
            idx_q     <= '0;
            par_bad_q <= 1'b0;
          end
          S_DATA: begin
            shift_q[idx_q] <= rx_sync_i;
            idx_q          <= idx_q + 3'd1;
          end
          S_PARITY: par_bad_q <= (rx_sync_i != ((^shift_q) ^ ODD_BIT));
          default: ;
        endcase
      end
    end
  end

  // ---- registered result interface ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o  <= frame_bad;
      parity_err_o <= par_hit;
      overrun_o    <= drop;
      if (load) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
